// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl
//   Owns the circle centre for the VGA image generator. Once per frame (at the
//   start of vertical blanking) the centre is stepped by STEP_X/STEP_Y in the
//   current direction. It bounces off the edges so that the whole circle of
//   RADIUS stays on screen.
//
// Ports
//   clk25      in   25 MHz pixel clock
//   reset      in   asynchronous, active-high reset
//   Vactive    in   vertical active window from the sync generator
//   enable     in   1 = motion allowed, 0 = freeze at the current position
//   pause      in   1 = ignore frame ends (the divider holds its count)
//   CircleCol  out  centre column (10 bits)
//   CircleRow  out  centre row (9 bits)
//   bounce     out  one-cycle pulse when an update hit one or more walls
//   dir        out  {dir_y, dir_x}; 0 = increasing, 1 = decreasing
//
// Optional build macro
//   BALL_SPEEDUP_EN : both step sizes grow by 1 (saturating at 15) on every
//                     4th bounce pulse.

module ball_motion_ctrl #(
  parameter int unsigned H_RES     = 640,
  parameter int unsigned V_RES     = 480,
  parameter int unsigned RADIUS    = 30,
  parameter int unsigned STEP_X    = 2,
  parameter int unsigned STEP_Y    = 1,
  parameter int unsigned FRAME_DIV = 1,
  parameter int unsigned START_COL = 320,
  parameter int unsigned START_ROW = 240
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic       Vactive,
  input  logic       enable,
  input  logic       pause,
  output logic [9:0] CircleCol,
  output logic [8:0] CircleRow,
  output logic       bounce,
  output logic [1:0] dir
);

  localparam logic [10:0] COL_MIN  = 11'(RADIUS);
  localparam logic [10:0] COL_MAX  = 11'(H_RES - 1 - RADIUS);
  localparam logic [9:0]  ROW_MIN  = 10'(RADIUS);
  localparam logic [9:0]  ROW_MAX  = 10'(V_RES - 1 - RADIUS);
  localparam logic [7:0]  DIV_LAST = 8'(FRAME_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STEP_X, S_STEP_Y} state_t;

  state_t      state_q, state_d;
  logic        vactive_q, vactive_d;
  logic [7:0]  div_q, div_d;
  logic [9:0]  col_q, col_d;
  logic [8:0]  row_q, row_d;
  logic        dir_x_q, dir_x_d;
  logic        dir_y_q, dir_y_d;
  logic        hit_x_q, hit_x_d;
  logic        bounce_q, bounce_d;

  logic        tick, count_en, fire, hit_y;
  logic [10:0] col_sum, col_lim;
  logic [9:0]  row_sum, row_lim;
  logic [3:0]  step_x, step_y;

`ifdef BALL_SPEEDUP_EN
  logic [3:0] step_x_q, step_x_d;
  logic [3:0] step_y_q, step_y_d;
  logic [1:0] bcnt_q, bcnt_d;

  assign step_x = step_x_q;
  assign step_y = step_y_q;

  always_comb begin
    step_x_d = step_x_q;
    step_y_d = step_y_q;
    bcnt_d   = bcnt_q;
    if (bounce_q) begin
      bcnt_d = bcnt_q + 2'd1;
      // Counter wraps on this pulse: every 4th bounce speeds the ball up.
      if (bcnt_q == 2'd3) begin
        if (step_x_q != 4'd15) step_x_d = step_x_q + 4'd1;
        if (step_y_q != 4'd15) step_y_d = step_y_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      step_x_q <= 4'(STEP_X);
      step_y_q <= 4'(STEP_Y);
      bcnt_q   <= '0;
    end else begin
      step_x_q <= step_x_d;
      step_y_q <= step_y_d;
      bcnt_q   <= bcnt_d;
    end
  end
`else
  assign step_x = 4'(STEP_X);
  assign step_y = 4'(STEP_Y);
`endif

  // Falling edge of Vactive marks the start of vertical blanking.
  assign tick     = vactive_q & ~Vactive;
  assign count_en = tick & enable & ~pause;
  assign fire     = count_en & (div_q == DIV_LAST);

  // One extra bit of headroom so the bound tests never wrap.
  assign col_sum = {1'b0, col_q} + 11'(step_x);
  assign col_lim = COL_MIN + 11'(step_x);
  assign row_sum = {1'b0, row_q} + 10'(step_y);
  assign row_lim = ROW_MIN + 10'(step_y);

  always_comb begin
    state_d   = state_q;
    vactive_d = Vactive;
    div_d     = div_q;
    col_d     = col_q;
    row_d     = row_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    hit_x_d   = hit_x_q;
    bounce_d  = 1'b0;
    hit_y     = 1'b0;

    if (count_en) begin
      div_d = fire ? '0 : div_q + 8'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!enable)   state_d = S_IDLE;
        else if (fire) state_d = S_STEP_X;
      end
      S_STEP_X: begin
        hit_x_d = 1'b0;
        if (!dir_x_q) begin
          if (col_sum > COL_MAX) begin
            col_d   = COL_MAX[9:0];
            dir_x_d = 1'b1;
            hit_x_d = 1'b1;
          end else begin
            col_d = col_sum[9:0];
          end
        end else begin
          if ({1'b0, col_q} < col_lim) begin
            col_d   = COL_MIN[9:0];
            dir_x_d = 1'b0;
            hit_x_d = 1'b1;
          end else begin
            col_d = col_q - 10'(step_x);
          end
        end
        state_d = S_STEP_Y;
      end
      S_STEP_Y: begin
        if (!dir_y_q) begin
          if (row_sum > ROW_MAX) begin
            row_d   = ROW_MAX[8:0];
            dir_y_d = 1'b1;
            hit_y   = 1'b1;
          end else begin
            row_d = row_sum[8:0];
          end
        end else begin
          if ({1'b0, row_q} < row_lim) begin
            row_d   = ROW_MIN[8:0];
            dir_y_d = 1'b0;
            hit_y   = 1'b1;
          end else begin
            row_d = row_q - 9'(step_y);
          end
        end
        // A corner hit still produces a single pulse.
        bounce_d = hit_x_q | hit_y;
        state_d  = enable ? S_WAIT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      vactive_q <= 1'b0;
      div_q     <= '0;
      col_q     <= 10'(START_COL);
      row_q     <= 9'(START_ROW);
      dir_x_q   <= 1'b0;
      dir_y_q   <= 1'b0;
      hit_x_q   <= 1'b0;
      bounce_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      vactive_q <= vactive_d;
      div_q     <= div_d;
      col_q     <= col_d;
      row_q     <= row_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      hit_x_q   <= hit_x_d;
      bounce_q  <= bounce_d;
    end
  end

  assign CircleCol = col_q;
  assign CircleRow = row_q;
  assign bounce    = bounce_q;
  assign dir       = {dir_y_q, dir_x_q};

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Bench for ball_motion_ctrl: three instances (default, corner preload,
// FRAME_DIV=3) share one stimulus stream and are compared each cycle against a
// frame-level model of the motion rules.

module tb_ball_motion_ctrl;

  logic clk25   = 1'b0;
  logic clk_run = 1'b1;
  logic reset   = 1'b0;
  logic Vactive = 1'b0;
  logic enable  = 1'b0;
  logic pause   = 1'b0;

  logic [9:0] col_w    [3];
  logic [8:0] row_w    [3];
  logic       bounce_w [3];
  logic [1:0] dir_w    [3];

  always begin
    #20;
    if (clk_run) clk25 = ~clk25;
  end

  ball_motion_ctrl u_a (
    .clk25(clk25), .reset(reset), .Vactive(Vactive), .enable(enable), .pause(pause),
    .CircleCol(col_w[0]), .CircleRow(row_w[0]), .bounce(bounce_w[0]), .dir(dir_w[0])
  );

  ball_motion_ctrl #(.START_COL(608), .START_ROW(449)) u_b (
    .clk25(clk25), .reset(reset), .Vactive(Vactive), .enable(enable), .pause(pause),
    .CircleCol(col_w[1]), .CircleRow(row_w[1]), .bounce(bounce_w[1]), .dir(dir_w[1])
  );

  ball_motion_ctrl #(.FRAME_DIV(3)) u_c (
    .clk25(clk25), .reset(reset), .Vactive(Vactive), .enable(enable), .pause(pause),
    .CircleCol(col_w[2]), .CircleRow(row_w[2]), .bounce(bounce_w[2]), .dir(dir_w[2])
  );

  localparam int COL_LO = 30;
  localparam int COL_HI = 609;
  localparam int ROW_LO = 30;
  localparam int ROW_HI = 449;

  int p_scol [3] = '{320, 608, 320};
  int p_srow [3] = '{240, 449, 240};
  int p_fdiv [3] = '{1, 1, 3};

  // Model state: visible outputs, pending update, and update progress
  // (0 = none, 1 = column lands next edge, 2 = row/bounce land next edge).
  int m_col [3], m_row [3], m_dx [3], m_dy [3], m_bnc [3];
  int m_cnt [3], m_phase [3], m_sx [3], m_sy [3], m_bcnt [3];
  int n_col [3], n_row [3], n_dx [3], n_dy [3], n_hit [3];
  logic va_prev, en_prev;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int bounce_seen_b = 0;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_col[i] = p_scol[i]; m_row[i] = p_srow[i];
      m_dx[i] = 0; m_dy[i] = 0; m_bnc[i] = 0;
      m_cnt[i] = 0; m_phase[i] = 0; m_sx[i] = 2; m_sy[i] = 1; m_bcnt[i] = 0;
    end
    va_prev = 1'b0;
    en_prev = 1'b0;
  endfunction

  function automatic void axis_step(input int pos, input int d, input int step,
                                    input int lo, input int hi,
                                    output int npos, output int nd, output int hit);
    nd = d; hit = 0;
    if (d == 0) begin
      if (pos + step > hi) begin npos = hi; nd = 1; hit = 1; end
      else npos = pos + step;
    end else begin
      if (pos - step < lo) begin npos = lo; nd = 0; hit = 1; end
      else npos = pos - step;
    end
  endfunction

  // Advances the model across the next rising edge, given the inputs the DUT
  // will sample there. Motion is armed only if enable was high the cycle before.
  function automatic void model_step(input logic en, input logic pa, input logic va);
    logic tick;
    logic fire;
    int hx, hy;
    tick = va_prev & ~va;
    for (int i = 0; i < 3; i++) begin
      fire = 1'b0;
      m_bnc[i] = 0;
      if (tick && en && !pa) begin
        m_cnt[i]++;
        if (m_cnt[i] == p_fdiv[i]) begin m_cnt[i] = 0; fire = 1'b1; end
      end
      if (m_phase[i] == 1) begin
        m_col[i] = n_col[i]; m_dx[i] = n_dx[i]; m_phase[i] = 2;
      end else if (m_phase[i] == 2) begin
        m_row[i] = n_row[i]; m_dy[i] = n_dy[i]; m_bnc[i] = n_hit[i]; m_phase[i] = 0;
`ifdef BALL_SPEEDUP_EN
        if (n_hit[i] != 0) begin
          m_bcnt[i] = (m_bcnt[i] + 1) % 4;
          if (m_bcnt[i] == 0) begin
            if (m_sx[i] < 15) m_sx[i]++;
            if (m_sy[i] < 15) m_sy[i]++;
          end
        end
`endif
      end else if (fire && en_prev) begin
        axis_step(m_col[i], m_dx[i], m_sx[i], COL_LO, COL_HI, n_col[i], n_dx[i], hx);
        axis_step(m_row[i], m_dy[i], m_sy[i], ROW_LO, ROW_HI, n_row[i], n_dy[i], hy);
        n_hit[i] = (hx != 0 || hy != 0) ? 1 : 0;
        m_phase[i] = 1;
      end
    end
    va_prev = va;
    en_prev = en;
  endfunction

  task automatic check_out(input int i);
    n_total++;
    if (int'(col_w[i]) == m_col[i] && int'(row_w[i]) == m_row[i] &&
        int'(dir_w[i]) == (m_dy[i] * 2 + m_dx[i]) && int'(bounce_w[i]) == m_bnc[i])
      n_pass++;
    else
      $display("FAIL out%0d cyc=%0d got col=%0d row=%0d dir=%0d bounce=%0d want col=%0d row=%0d dir=%0d bounce=%0d",
               i, cyc, col_w[i], row_w[i], dir_w[i], bounce_w[i],
               m_col[i], m_row[i], m_dy[i] * 2 + m_dx[i], m_bnc[i]);
  endtask

  task automatic check_lit(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s got=%0d want=%0d", name, got, want);
  endtask

  task automatic cycle(input logic en, input logic pa, input logic va);
    @(negedge clk25);
    cyc++;
    for (int i = 0; i < 3; i++) check_out(i);
    if (bounce_w[1]) bounce_seen_b++;
    enable = en; pause = pa; Vactive = va;
    model_step(en, pa, va);
  endtask

  // Vactive high for act cycles then low for blank cycles; enable toggles at
  // frame cycle flip_at (negative = never).
  task automatic frame(input int act, input int blank, input logic en,
                       input logic pa, input int flip_at);
    logic e;
    e = en;
    for (int k = 0; k < act + blank; k++) begin
      if (k == flip_at) e = ~e;
      cycle(e, pa, (k < act) ? 1'b1 : 1'b0);
    end
  endtask

  // Must be called with no clock edge in the next 2 time units.
  task automatic apply_reset();
    reset = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) check_out(i);
    check_lit("rst_a_col", int'(col_w[0]), 320);
    check_lit("rst_a_row", int'(row_w[0]), 240);
    check_lit("rst_b_col", int'(col_w[1]), 608);
    check_lit("rst_b_dir", int'(dir_w[1]), 0);
    check_lit("rst_a_bounce", int'(bounce_w[0]), 0);
    #1;
    reset = 1'b0;
    model_step(enable, pause, Vactive);
  endtask

  initial begin
    #5;
    apply_reset();
    repeat (3) cycle(1'b0, 1'b0, 1'b1);

    bounce_seen_b = 0;
    frame(10, 8, 1'b1, 1'b0, -1);
    check_lit("f1_a_col", int'(col_w[0]), 322);
    check_lit("f1_a_row", int'(row_w[0]), 241);
    check_lit("f1_a_dir", int'(dir_w[0]), 0);
    check_lit("f1_b_col", int'(col_w[1]), 609);
    check_lit("f1_b_row", int'(row_w[1]), 449);
    check_lit("f1_b_dir", int'(dir_w[1]), 3);
    check_lit("f1_b_bounce_cycles", bounce_seen_b, 1);
    check_lit("f1_c_col", int'(col_w[2]), 320);

    frame(10, 8, 1'b1, 1'b0, -1);
    check_lit("f2_a_col", int'(col_w[0]), 324);
    check_lit("f2_b_col", int'(col_w[1]), 607);
    check_lit("f2_b_row", int'(row_w[1]), 448);
    check_lit("f2_c_col", int'(col_w[2]), 320);

    frame(10, 8, 1'b1, 1'b0, -1);
    check_lit("f3_c_col", int'(col_w[2]), 322);
    check_lit("f3_c_row", int'(row_w[2]), 241);
    repeat (3) frame(10, 8, 1'b1, 1'b0, -1);
    check_lit("f6_c_col", int'(col_w[2]), 324);
    check_lit("f6_c_row", int'(row_w[2]), 242);
    check_lit("f6_a_col", int'(col_w[0]), 332);
    check_lit("f6_a_row", int'(row_w[0]), 246);

    repeat (2) frame(10, 8, 1'b1, 1'b1, -1);
    check_lit("pause_a_col", int'(col_w[0]), 332);
    check_lit("pause_a_row", int'(row_w[0]), 246);

    // enable drops in the cycle right after the tick (update in flight)
    frame(10, 8, 1'b1, 1'b0, 11);
    check_lit("drop_a_col", int'(col_w[0]), 334);
    check_lit("drop_a_row", int'(row_w[0]), 247);
    repeat (2) frame(10, 8, 1'b0, 1'b0, -1);
    check_lit("idle_a_col", int'(col_w[0]), 334);
    check_lit("idle_a_row", int'(row_w[0]), 247);

    // Reset with the clock stopped low between ticks.
    frame(6, 0, 1'b1, 1'b0, -1);
    clk_run = 1'b0;
    #200;
    apply_reset();
    #200;
    clk_run = 1'b1;

    for (int f = 0; f < 500; f++) begin
      int act, blank, flip;
      logic en, pa;
      act   = $urandom_range(30, 12);
      blank = $urandom_range(12, 5);
      en    = ($urandom_range(7, 0) != 0);
      pa    = ($urandom_range(9, 0) == 0);
      flip  = ($urandom_range(5, 0) == 0) ? int'($urandom_range(act + blank - 1, 0)) : -1;
      frame(act, blank, en, pa, flip);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog got=no_finish want=finish_before_4ms");
    $fatal(1, "watchdog expired");
  end

endmodule
